// File: rtl/seq_divider_pkg.sv
// Shared types for the iterative restoring divider.
// Holds the FSM state enum and its encoding width.
package seq_divider_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration.
// Ports: rem_acc/dvd_msb/dvsor in; rem_next, qbit out.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_acc,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvsor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_acc, dvd_msb};
  // Extra top bit acts as the borrow of the trial subtract.
  assign diff = {1'b0, shifted} - {2'b00, dvsor};
  assign qbit = ~diff[WIDTH+1];
  // rem_acc < dvsor always, so a kept difference fits WIDTH bits.
  assign rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Ports: clk, reset, in_valid/in_ready, dvdend, dvsor,
// out_valid/out_ready, quot, rem, div0.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dvdend,
  input  logic [WIDTH-1:0] dvsor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             qbit;
  logic             last;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_acc (acc),
    .dvd_msb (dvd[WIDTH-1]),
    .dvsor   (dvs),
    .rem_next(acc_nxt),
    .qbit    (qbit)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign dvd_mag = dvdend[WIDTH-1] ? -dvdend : dvdend;
  assign dvs_mag = dvsor[WIDTH-1] ? -dvsor : dvsor;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      div0      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            if (dvsor == '0) begin
              quot  <= '1;
              rem   <= dvdend;
              div0  <= 1'b1;
              state <= DONE;
            end else begin
              div0  <= 1'b0;
              state <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
              dvd   <= dvd_mag;
              dvs   <= dvs_mag;
              neg_q <= dvdend[WIDTH-1] ^ dvsor[WIDTH-1];
              neg_r <= dvdend[WIDTH-1];
`else
              dvd   <= dvdend;
              dvs   <= dvsor;
`endif
            end
          end
        end
        CALC: begin
          // Quotient bits fill dvd from the bottom as it drains.
          dvd <= {dvd[WIDTH-2:0], qbit};
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            quot <= {dvd[WIDTH-2:0], qbit};
            rem  <= acc_nxt;
`ifdef SEQ_DIVIDER_SIGNED_EN
            state <= FIX;
`else
            state <= DONE;
`endif
          end
        end
        FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          if (neg_q) quot <= -quot;
          if (neg_r) rem <= -rem;
`endif
          state <= DONE;
        end
        DONE: begin
          // Results land on entry; valid rises one clock later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
// Covers latency, patterns, div0, backpressure, reset.
module tb_seq_divider;

  localparam int WIDTH = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dvdend;
  logic [WIDTH-1:0] dvsor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div0;

  int tests = 0;
  int fails = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dvdend   (dvdend),
    .dvsor    (dvsor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot     (quot),
    .rem      (rem),
    .div0     (div0)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    dvdend   = a;
    dvsor    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL timeout: out_valid=%0b after %0d clocks, required 1",
               out_valid, n);
    end
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dvdend    = '0;
    dvsor     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== '0 ||
        rem !== '0 || div0 !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%0b vld=%0b q=%h r=%h d0=%0b, required 1 0 0 0 0",
               in_ready, out_valid, quot, rem, div0);
    end
  endtask

  task automatic test_latency();
    int n;
    start_op(32'd100, 32'd7);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL busy_ready: in_ready=%0b, required 0", in_ready);
    end
    wait_result(n);
    tests++;
    if (n !== LAT) begin
      fails++;
      $display("FAIL latency: %0d clocks, required %0d", n, LAT);
    end
    tests++;
    if (quot !== 32'd14 || rem !== 32'd2 || div0 !== 1'b0) begin
      fails++;
      $display("FAIL div_100_7: q=%0d r=%0d d0=%0b, required 14 2 0",
               quot, rem, div0);
    end
    accept_result();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL handshake_back: rdy=%0b vld=%0b, required 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_patterns();
    int n;
    start_op(32'hFFFF_FFFF, 32'd1);
    wait_result(n);
    tests++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'd0 || div0 !== 1'b0) begin
      fails++;
      $display("FAIL div_max_1: q=%h r=%h d0=%0b, required ffffffff 0 0",
               quot, rem, div0);
    end
    accept_result();
    start_op(32'd5, 32'd9);
    wait_result(n);
    tests++;
    if (quot !== 32'd0 || rem !== 32'd5 || div0 !== 1'b0) begin
      fails++;
      $display("FAIL div_5_9: q=%0d r=%0d d0=%0b, required 0 5 0",
               quot, rem, div0);
    end
    accept_result();
    start_op(32'd1000, 32'd3);
    wait_result(n);
    tests++;
    if (quot !== 32'd333 || rem !== 32'd1) begin
      fails++;
      $display("FAIL div_1000_3: q=%0d r=%0d, required 333 1", quot, rem);
    end
    accept_result();
  endtask

  task automatic test_div0();
    int n;
    start_op(32'd1234, 32'd0);
    wait_result(n);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL div0_latency: %0d clocks, required 1", n);
    end
    tests++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'd1234 || div0 !== 1'b1) begin
      fails++;
      $display("FAIL div0_result: q=%h r=%0d d0=%0b, required ffffffff 1234 1",
               quot, rem, div0);
    end
    accept_result();
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    start_op(32'd200, 32'd3);
    wait_result(n);
    dvdend   = 32'd9;
    dvsor    = 32'd3;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          quot !== 32'd66 || rem !== 32'd2) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold: %0d bad cycles (vld=%0b rdy=%0b q=%0d r=%0d), required 0",
               bad, out_valid, in_ready, quot, rem);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL release: rdy=%0b vld=%0b, required 1 0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL next_accept: in_ready=%0b, required 0", in_ready);
    end
    wait_result(n);
    tests++;
    if (n !== LAT || quot !== 32'd3 || rem !== 32'd0) begin
      fails++;
      $display("FAIL div_9_3: n=%0d q=%0d r=%0d, required %0d 3 0",
               n, quot, rem, LAT);
    end
    accept_result();
  endtask

  task automatic test_mid_reset();
    int n;
    start_op(32'd1000, 32'd7);
    repeat (16) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== '0 ||
        rem !== '0 || div0 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: rdy=%0b vld=%0b q=%h r=%h d0=%0b, required 1 0 0 0 0",
               in_ready, out_valid, quot, rem, div0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_op(32'd50, 32'd5);
    wait_result(n);
    tests++;
    if (quot !== 32'd10 || rem !== 32'd0 || div0 !== 1'b0) begin
      fails++;
      $display("FAIL div_50_5: q=%0d r=%0d d0=%0b, required 10 0 0",
               quot, rem, div0);
    end
    accept_result();
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    int n;
    start_op(32'hFFFF_FFF9, 32'd2);
    wait_result(n);
    tests++;
    if (quot !== 32'hFFFF_FFFD || rem !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL sdiv_m7_2: q=%h r=%h, required fffffffd ffffffff",
               quot, rem);
    end
    accept_result();
    start_op(32'd7, 32'hFFFF_FFFE);
    wait_result(n);
    tests++;
    if (quot !== 32'hFFFF_FFFD || rem !== 32'd1) begin
      fails++;
      $display("FAIL sdiv_7_m2: q=%h r=%h, required fffffffd 00000001",
               quot, rem);
    end
    accept_result();
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(n);
    tests++;
    if (quot !== 32'h8000_0000 || rem !== 32'd0 || div0 !== 1'b0) begin
      fails++;
      $display("FAIL sdiv_min_m1: q=%h r=%h d0=%0b, required 80000000 0 0",
               quot, rem, div0);
    end
    accept_result();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_patterns();
    test_div0();
    test_back_to_back();
    test_mid_reset();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
